// File: rtl/rvcpu_pkg.sv
// Shared defaults, instruction field layout and operand-fetch state encoding.
package rvcpu_pkg;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_REG_AW   = 4;
    localparam int DEF_NUM_REGS = 8;

    // Instruction layout: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2 / imm4
    localparam int OPC_LSB = 12;
    localparam int OPC_W   = 4;
    localparam int RD_LSB  = 8;
    localparam int RS1_LSB = 4;
    localparam int RS2_LSB = 0;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 4;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LIVE  = 2'd1,
        ST_HELD  = 2'd2
    } of_state_e;
endpackage

// File: rtl/operand_fetch_if.sv
// Upstream instruction handshake and downstream decoded-bundle handshake.
interface operand_fetch_if #(
    parameter int DATA_W = rvcpu_pkg::DEF_DATA_W,
    parameter int REG_AW = rvcpu_pkg::DEF_REG_AW
);
    logic                       in_valid;
    logic                       in_ready;
    logic [DATA_W-1:0]          in_instr;
    logic                       out_valid;
    logic                       out_ready;
    logic [rvcpu_pkg::OPC_W-1:0] out_opcode;
    logic [REG_AW-1:0]          out_rd;
    logic [DATA_W-1:0]          out_op1;
    logic [DATA_W-1:0]          out_op2;
    logic [DATA_W-1:0]          out_imm;
    logic                       out_illegal;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_opcode, out_rd, out_op1, out_op2, out_imm, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_opcode, out_rd, out_op1, out_op2, out_imm, out_illegal
    );
endinterface

// File: rtl/operand_fwd.sv
// One source operand: writeback bypass, accept-edge forward capture and stall hold register.
module operand_fwd import rvcpu_pkg::*; #(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int REG_AW   = DEF_REG_AW,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              accept,
    input  of_state_e         state,
    input  logic              out_ready,
    input  logic [REG_AW-1:0] rs_in,
    input  logic [REG_AW-1:0] rs_s1,
    input  logic [DATA_W-1:0] rf_rdata,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] op
);
    logic              in_ok, s1_ok, hit_in, hit_s1;
    logic              fwd_vld_q, fwd_vld_d;
    logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] base;

    assign in_ok  = 32'(rs_in) < NUM_REGS;
    assign s1_ok  = 32'(rs_s1) < NUM_REGS;
    assign hit_in = wb_en && in_ok && (wb_addr == rs_in);
    assign hit_s1 = wb_en && s1_ok && (wb_addr == rs_s1);

    always_comb begin
        base       = rf_rdata;
        op         = '0;
        fwd_vld_d  = fwd_vld_q;
        fwd_data_d = fwd_data_q;
        hold_d     = hold_q;

        // The register file returns pre-write data for a write on the accept edge
        if (state == ST_HELD)   base = hold_q;
        else if (fwd_vld_q)     base = fwd_data_q;

        if (state != ST_EMPTY)  op = hit_s1 ? wb_data : base;

        if (accept) begin
            fwd_vld_d  = hit_in;
            fwd_data_d = hit_in ? wb_data : '0;
        end

        if (state == ST_LIVE && !out_ready)  hold_d = op;
        else if (state == ST_HELD && hit_s1) hold_d = wb_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_vld_q  <= 1'b0;
            fwd_data_q <= '0;
            hold_q     <= '0;
        end else begin
            fwd_vld_q  <= fwd_vld_d;
            fwd_data_q <= fwd_data_d;
            hold_q     <= hold_d;
        end
    end
endmodule

// File: rtl/operand_fetch.sv
// Single-stage operand fetch: decodes fields, reads the register file, forwards writebacks.
module operand_fetch import rvcpu_pkg::*; #(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int REG_AW   = DEF_REG_AW,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic              clk,
    input  logic              rst_n,
    operand_fetch_if.slave    bus,
    output logic [REG_AW-1:0] rf_raddr1,
    output logic [REG_AW-1:0] rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data
);
    of_state_e         state_q, state_d;
    logic              accept;
    logic [OPC_W-1:0]  opc_q, opc_d;
    logic [REG_AW-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic              ill_q, ill_d;
    logic [REG_AW-1:0] in_rd, in_rs1, in_rs2;
    logic [IMM_W-1:0]  in_imm4;

    function automatic logic bad_idx(input logic [REG_AW-1:0] idx);
        return 32'(idx) >= NUM_REGS;
    endfunction

    assign in_rd     = bus.in_instr[RD_LSB  +: REG_AW];
    assign in_rs1    = bus.in_instr[RS1_LSB +: REG_AW];
    assign in_rs2    = bus.in_instr[RS2_LSB +: REG_AW];
    assign in_imm4   = bus.in_instr[IMM_LSB +: IMM_W];
    assign rf_raddr1 = in_rs1;
    assign rf_raddr2 = in_rs2;

    assign bus.in_ready    = (state_q == ST_EMPTY) || bus.out_ready;
    assign accept          = bus.in_valid && bus.in_ready;
    assign bus.out_valid   = (state_q != ST_EMPTY);
    assign bus.out_opcode  = opc_q;
    assign bus.out_rd      = rd_q;
    assign bus.out_imm     = imm_q;
    assign bus.out_illegal = ill_q;

    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        imm_d   = imm_q;
        ill_d   = ill_q;

        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_LIVE;
            default:  state_d = !bus.out_ready ? ST_HELD : (accept ? ST_LIVE : ST_EMPTY);
        endcase

        if (accept) begin
            opc_d = bus.in_instr[OPC_LSB +: OPC_W];
            rd_d  = in_rd;
            rs1_d = in_rs1;
            rs2_d = in_rs2;
            imm_d = {{(DATA_W-IMM_W){in_imm4[IMM_W-1]}}, in_imm4};
            ill_d = bad_idx(in_rd) || bad_idx(in_rs1) || bad_idx(in_rs2);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            opc_q   <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            imm_q   <= imm_d;
            ill_q   <= ill_d;
        end
    end

    operand_fwd #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_REGS(NUM_REGS)) u_fwd1 (
        .clk(clk), .rst_n(rst_n), .accept(accept), .state(state_q), .out_ready(bus.out_ready),
        .rs_in(in_rs1), .rs_s1(rs1_q), .rf_rdata(rf_rdata1),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .op(bus.out_op1)
    );

    operand_fwd #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_REGS(NUM_REGS)) u_fwd2 (
        .clk(clk), .rst_n(rst_n), .accept(accept), .state(state_q), .out_ready(bus.out_ready),
        .rs_in(in_rs2), .rs_s1(rs2_q), .rf_rdata(rf_rdata2),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .op(bus.out_op2)
    );
endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: directed instructions, behavioural register file.
module tb_operand_fetch;
    import rvcpu_pkg::*;

    typedef struct packed {
        logic [3:0]  opc;
        logic [3:0]  rd;
        logic [15:0] op1;
        logic [15:0] op2;
        logic [15:0] imm;
        logic        ill;
    } exp_t;

    // Bundle compare for illegal instructions ignores op1/op2
    localparam logic [63:0] ILL_MASK = 64'h01FE_0000_0001_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  rf_raddr1, rf_raddr2;
    logic [15:0] rf_rdata1, rf_rdata2;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic [15:0] rf [16];

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    operand_fetch_if #(.DATA_W(16), .REG_AW(4)) bus ();

    operand_fetch dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    // Register file: registered read returning pre-write data
    always @(posedge clk) begin
        rf_rdata1 <= rf[rf_raddr1];
        rf_rdata2 <= rf[rf_raddr2];
        if (wb_en) rf[wb_addr] <= wb_data;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, want);
    endtask

    function automatic logic [63:0] outs();
        return 64'({bus.out_opcode, bus.out_rd, bus.out_op1, bus.out_op2, bus.out_imm, bus.out_illegal});
    endfunction

    function automatic exp_t mk(input logic [3:0] opc, input logic [3:0] rd, input logic [15:0] op1,
                                input logic [15:0] op2, input logic [15:0] imm, input logic ill);
        return {opc, rd, op1, op2, imm, ill};
    endfunction

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        step(1);
        wb_en = 1'b0;
    endtask

    task automatic send(input logic [15:0] ins, input bit track, input exp_t e, output int waited);
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_instr = ins;
        #1;
        while (!bus.in_ready && waited < 50) begin step(1); waited++; end
        if (!bus.in_ready) begin
            n_chk++;
            $display("FAIL send_timeout: instr %h never accepted", ins);
        end else if (track) begin
            sb.push_back(e);
        end
        step(1);
        bus.in_valid = 1'b0;
    endtask

    task automatic stall_chk(input string tag, input logic [15:0] op2_want);
        chk({tag, "_op2"}, 64'(bus.out_op2), 64'(op2_want));
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
        chk({tag, "_stable"},
            64'({bus.out_valid, bus.out_opcode, bus.out_rd, bus.out_op1, bus.out_imm, bus.out_illegal}),
            64'({1'b1, 4'h1, 4'h1, 16'hBEEF, 16'h0003, 1'b0}));
    endtask

    // Monitor: pops one expected bundle per downstream handshake
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_bundle: got %0h expected none", outs());
                end else begin
                    e = sb.pop_front();
                    if (e.ill) chk("bundle_illegal", outs() & ILL_MASK, 64'(e) & ILL_MASK);
                    else       chk("bundle", outs(), 64'(e));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int w;
        rst_n = 1'b1; bus.in_valid = 1'b0; bus.in_instr = '0; bus.out_ready = 1'b1;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_outs_zero", outs(), 64'd0);
        step(1);
        rst_n = 1'b1;

        wr(4'd1, 16'h1111); wr(4'd2, 16'h1234); wr(4'd3, 16'h0042); wr(4'd4, 16'h0404);
        step(2);

        // Basic fetch, latency 1
        send(16'h1123, 1'b1, mk(4'h1, 4'h1, 16'h1234, 16'h0042, 16'h0003, 1'b0), w);
        chk("t1_latency", 64'(bus.out_valid), 64'd1);
        step(2);

        // Writeback on the accept edge beats the stale register-file read
        wb_en = 1'b1; wb_addr = 4'd2; wb_data = 16'hBEEF;
        send(16'h1123, 1'b1, mk(4'h1, 4'h1, 16'hBEEF, 16'h0042, 16'h0003, 1'b0), w);
        wb_en = 1'b0;
        step(2);

        // Three-cycle stall with a writeback to rs2 in the second stall cycle
        bus.out_ready = 1'b0;
        send(16'h1123, 1'b1, mk(4'h1, 4'h1, 16'hBEEF, 16'h5555, 16'h0003, 1'b0), w);
        #1 stall_chk("t3_c1", 16'h0042);
        step(1);
        wb_en = 1'b1; wb_addr = 4'd3; wb_data = 16'h5555;
        #1 stall_chk("t3_c2", 16'h5555);
        step(1);
        wb_en = 1'b0;
        #1 stall_chk("t3_c3", 16'h5555);
        step(1);
        bus.out_ready = 1'b1;
        step(2);

        // Back-to-back, no bubble
        send(16'h2012, 1'b1, mk(4'h2, 4'h0, 16'h1111, 16'hBEEF, 16'h0002, 1'b0), w);
        chk("t4_first_out", 64'({bus.out_valid, bus.out_opcode}), 64'h12);
        send(16'h3034, 1'b1, mk(4'h3, 4'h0, 16'h5555, 16'h0404, 16'h0004, 1'b0), w);
        chk("t4_second_out", 64'({bus.out_valid, bus.out_opcode}), 64'h13);
        step(2);

        // Illegal indices and negative immediate (rs2=15 also flags illegal)
        send(16'h4F12, 1'b1, mk(4'h4, 4'hF, 16'h0000, 16'h0000, 16'h0002, 1'b1), w);
        step(2);
        send(16'h402F, 1'b1, mk(4'h4, 4'h0, 16'h0000, 16'h0000, 16'hFFFF, 1'b1), w);
        step(2);

        // Reset while HELD discards the instruction
        bus.out_ready = 1'b0;
        send(16'h1123, 1'b0, mk(4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 1'b0), w);
        step(2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("t6_rst_outs_zero", outs(), 64'd0);
        step(1);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        send(16'h1123, 1'b1, mk(4'h1, 4'h1, 16'hBEEF, 16'h5555, 16'h0003, 1'b0), w);
        chk("t6_first_accept_wait", 64'(w), 64'd0);
        chk("t6_latency", 64'(bus.out_valid), 64'd1);
        step(3);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
